// File: rtl/reg_share_arbiter.sv
// Two-requester arbiter guarding one shared WIDTH-bit register.
// Round-robin on contention, bounded hold while the other side waits.
module reg_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       REQ,
  input  logic [1:0]       WE,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic [1:0]       GNT,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             OWNER,
  output logic             WR_STB
);

  localparam logic [3:0] CNT_TOP = 4'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      Q      <= '0;
      WR_STB <= 1'b0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      WR_STB <= wr_en;
      if (wr_en) Q <= wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        case (REQ)
          2'b01:   state_nxt = GRANT0;
          2'b10:   state_nxt = GRANT1;
          2'b11:   state_nxt = last ? GRANT0 : GRANT1;
          default: state_nxt = IDLE;
        endcase
      end
      // Release is tested first so it wins over hold expiry.
      GRANT0: begin
        if (!REQ[0])                   state_nxt = REQ[1] ? GRANT1 : IDLE;
        else if (cnt == CNT_TOP && REQ[1]) state_nxt = GRANT1;
      end
      GRANT1: begin
        if (!REQ[1])                   state_nxt = REQ[0] ? GRANT0 : IDLE;
        else if (cnt == CNT_TOP && REQ[0]) state_nxt = GRANT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    last_nxt = last;
    if (state_nxt != state && state_nxt == GRANT0) last_nxt = 1'b0;
    if (state_nxt != state && state_nxt == GRANT1) last_nxt = 1'b1;
  end

  // Saturating hold counter; a lone requester never expires.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state || state_nxt == IDLE) cnt_nxt = '0;
    else if (cnt != CNT_TOP)                     cnt_nxt = cnt + 4'd1;
  end

  assign GNT   = {state == GRANT1, state == GRANT0};
  assign BUSY  = GNT[0] | GNT[1];
  assign OWNER = (state == GRANT1);

  // Write qualified by the pre-edge grant: a switching edge writes for the outgoing owner.
  assign wr_en   = (GNT[0] & WE[0]) | (GNT[1] & WE[1]);
  assign wr_data = GNT[1] ? D1 : D0;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: expected {GNT,Q,WR_STB} queued per cycle.
module tb_reg_share_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] REQ, WE;
  logic [7:0] D0, D1;
  logic [1:0] GNT, GNT1;
  logic [7:0] Q, Q1;
  logic       BUSY, OWNER, WR_STB, BUSY1, OWNER1, WR_STB1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] gnt;
    logic [7:0] q;
    logic       stb;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] sb1[$];

  always #5 CLK = ~CLK;

  reg_share_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .D0(D0), .D1(D1),
    .GNT(GNT), .Q(Q), .BUSY(BUSY), .OWNER(OWNER), .WR_STB(WR_STB));

  reg_share_arbiter #(.WIDTH(8), .HOLD_MAX(1)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .D0(D0), .D1(D1),
    .GNT(GNT1), .Q(Q1), .BUSY(BUSY1), .OWNER(OWNER1), .WR_STB(WR_STB1));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = 2'b00; WE = 2'b00; D0 = 8'h00; D1 = 8'h00;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, o;
    RST = 1'b1; REQ = 2'b11; WE = 2'b11; D0 = 8'hFF; D1 = 8'hEE;
    sb.push_back('{2'b00, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB};
    n_cmp++;
    if (o !== e || BUSY !== 1'b0 || OWNER !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: gnt=%b q=%h stb=%b busy=%b owner=%b, want gnt=%b q=%h stb=%b busy=0 owner=0",
               GNT, Q, WR_STB, BUSY, OWNER, e.gnt, e.q, e.stb);
    end
    RST = 1'b0; REQ = 2'b00; WE = 2'b00;
  endtask

  task automatic test_basic_write();
    exp_t e, o;
    do_reset();
    REQ = 2'b01; WE = 2'b01; D0 = 8'hA5;
    sb.push_back('{2'b01, 8'h00, 1'b0});
    sb.push_back('{2'b01, 8'hA5, 1'b1});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL basic_write[%0d]: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b",
                 i, GNT, Q, WR_STB, e.gnt, e.q, e.stb);
      end
    end
    WE = 2'b00; sb.push_back('{2'b01, 8'hA5, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL basic_stb_drop: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b",
               GNT, Q, WR_STB, e.gnt, e.q, e.stb);
    end
    REQ = 2'b00; sb.push_back('{2'b00, 8'hA5, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL basic_idle: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b",
               GNT, Q, WR_STB, e.gnt, e.q, e.stb);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    do_reset();
    REQ = 2'b11;
    for (int i = 0; i < 12; i++)
      sb.push_back('{(i / 4) % 2 == 0 ? 2'b01 : 2'b10, 8'h00, 1'b0});
    for (int i = 0; i < 12; i++) begin
      tick();
      e = sb.pop_front(); n_cmp++;
      if (GNT !== e.gnt || BUSY !== 1'b1 || OWNER !== e.gnt[1]) begin
        n_bad++;
        $display("FAIL hold[%0d]: gnt=%b busy=%b owner=%b, want gnt=%b busy=1 owner=%b",
                 i, GNT, BUSY, OWNER, e.gnt, e.gnt[1]);
      end
    end
    REQ = 2'b00; tick();
  endtask

  task automatic test_release();
    exp_t e, o;
    do_reset();
    REQ = 2'b01; WE = 2'b01; D0 = 8'h5A;
    sb.push_back('{2'b01, 8'h00, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL release_grant: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    sb.push_back('{2'b01, 8'h5A, 1'b1}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL release_write: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    REQ = 2'b10; WE = 2'b00;
    sb.push_back('{2'b10, 8'h5A, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL release_handoff: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    REQ = 2'b00;
    sb.push_back('{2'b00, 8'h5A, 1'b0});
    sb.push_back('{2'b00, 8'h5A, 1'b0});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL release_idle[%0d]: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", i, GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    end
  endtask

  task automatic test_ignore_we();
    exp_t e, o;
    do_reset();
    REQ = 2'b01;
    sb.push_back('{2'b01, 8'h00, 1'b0}); tick();
    void'(sb.pop_front());
    WE = 2'b10; D1 = 8'h3C;
    for (int i = 0; i < 3; i++) sb.push_back('{2'b01, 8'h00, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ignore_we[%0d]: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", i, GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    end
    REQ = 2'b00; WE = 2'b00; tick();
  endtask

  task automatic test_switch_write();
    exp_t e, o;
    do_reset();
    REQ = 2'b11;
    sb.push_back('{2'b01, 8'h00, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL switch_grant: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    REQ = 2'b10; WE = 2'b11; D0 = 8'h11; D1 = 8'h22;
    sb.push_back('{2'b10, 8'h11, 1'b1}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL switch_write_owner: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    REQ = 2'b00; WE = 2'b00;
    sb.push_back('{2'b00, 8'h11, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL switch_idle: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
  endtask

  task automatic test_no_expiry();
    exp_t e;
    int   bad_cycles = 0;
    do_reset();
    REQ = 2'b01;
    for (int i = 0; i < 20; i++) sb.push_back('{2'b01, 8'h00, 1'b0});
    for (int i = 0; i < 20; i++) begin
      tick();
      e = sb.pop_front();
      if (GNT !== e.gnt) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL no_expiry: %0d of 20 cycles without gnt=01, want 0", bad_cycles);
    end
    // Counter is saturated, so the waiting side is served on the very next edge.
    REQ = 2'b11;
    sb.push_back('{2'b10, 8'h00, 1'b0}); tick();
    e = sb.pop_front(); n_cmp++;
    if (GNT !== e.gnt) begin n_bad++; $display("FAIL expiry_switch: gnt=%b, want %b", GNT, e.gnt); end
    REQ = 2'b00; tick();
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    do_reset();
    REQ = 2'b01; WE = 2'b01; D0 = 8'hFF;
    sb.push_back('{2'b01, 8'h00, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rstmid_grant: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    RST = 1'b1;
    sb.push_back('{2'b00, 8'h00, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rstmid_discard: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    RST = 1'b0; REQ = 2'b11; WE = 2'b00;
    sb.push_back('{2'b01, 8'h00, 1'b0}); tick();
    e = sb.pop_front(); o = '{GNT, Q, WR_STB}; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rstmid_rearb: gnt=%b q=%h stb=%b, want gnt=%b q=%h stb=%b", GNT, Q, WR_STB, e.gnt, e.q, e.stb); end
    REQ = 2'b00; tick();
  endtask

  task automatic test_hold_one();
    logic [1:0] e;
    do_reset();
    REQ = 2'b11;
    for (int i = 0; i < 6; i++) sb1.push_back(i % 2 == 0 ? 2'b01 : 2'b10);
    for (int i = 0; i < 6; i++) begin
      tick();
      e = sb1.pop_front(); n_cmp++;
      if (GNT1 !== e) begin n_bad++; $display("FAIL hold_one[%0d]: gnt=%b, want %b", i, GNT1, e); end
    end
    REQ = 2'b00; tick();
  endtask

  initial begin
    RST = 1'b1; REQ = 2'b00; WE = 2'b00; D0 = 8'h00; D1 = 8'h00;
    test_reset();
    test_basic_write();
    test_hold();
    test_release();
    test_ignore_we();
    test_switch_write();
    test_no_expiry();
    test_reset_mid();
    test_hold_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
